// File: rtl/rr_arbiter_pkg.sv
// Shared defaults, FSM state type and width helpers for the round-robin arbiter.
// Widths are derived so that degenerate parameter values still give a 1-bit field.
package rr_arbiter_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 16;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  function automatic int clog2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

  localparam int DEF_IDX_W = clog2_min1(DEF_N);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit at or above the ptr bit, else wrap to the lowest.
// Zero latency; winner is all-zero when req is all-zero.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] winner
);

  logic [N-1:0] upper;
  logic [N-1:0] upper_low;
  logic [N-1:0] all_low;

  // ptr is one-hot, so ptr-1 masks every index below the priority position.
  assign upper     = req & ~(ptr - N'(1));
  assign upper_low = upper & (~upper + N'(1));
  assign all_low   = req & (~req + N'(1));
  assign winner    = (|upper) ? upper_low : all_low;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with hold-time limit: one-hot grant registered one edge after the deciding req.
// No backpressure; an owner releases via done, dropping its req, or hitting MAX_HOLD.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               req,
  input  logic                       done,
  output logic [N-1:0]               gnt,
  output logic                       gnt_valid,
  output logic [clog2_min1(N)-1:0]   gnt_idx,
  output logic                       timeout
);

  localparam int IW = clog2_min1(N);
  localparam int HW = clog2_min1(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : {HW{1'b1}};

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          vld_q, vld_d;
  logic          timeout_q, timeout_d;

  logic          owner_req;
  logic          hold_lim;
  logic          release_ev;
  logic [N-1:0]  ptr_rot;
  logic [N-1:0]  pick_ptr;
  logic [N-1:0]  winner;

  assign owner_req  = |(req & gnt_q);
  assign hold_lim   = (MAX_HOLD > 0) && (hold_q == HOLD_SAT);
  assign release_ev = (state_q == OWN) && (done || !owner_req || hold_lim);
  assign ptr_rot    = {gnt_q[N-2:0], gnt_q[N-1]};
  // Re-pick on the release edge uses the rotated pointer so there is no bubble cycle.
  assign pick_ptr   = release_ev ? ptr_rot : ptr_q;

  rr_pick #(.N(N)) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (winner)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|winner) begin
          state_d = OWN;
          gnt_d   = winner;
          hold_d  = '0;
        end
      end
      OWN: begin
        if (release_ev) begin
          ptr_d     = ptr_rot;
          hold_d    = '0;
          timeout_d = hold_lim && !done && owner_req;
          if (|winner) begin
            gnt_d = winner;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    idx_d = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_d[i]) idx_d = idx_d | IW'(i);
    end
    vld_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= N'(1);
      hold_q    <= '0;
      idx_q     <= '0;
      vld_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = vld_q;
  assign gnt_idx   = idx_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4, MAX_HOLD=4): vector table plus timeout and async-reset sequences.
module tb_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       to;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] ei, input logic et);
    logic ev;
    ev = |eg;
    checks++;
    if (gnt !== eg) begin
      errors++;
      $display("FAIL %s gnt: got %b want %b", name, gnt, eg);
    end
    checks++;
    if (gnt_valid !== ev) begin
      errors++;
      $display("FAIL %s gnt_valid: got %b want %b", name, gnt_valid, ev);
    end
    checks++;
    if (gnt_idx !== ei) begin
      errors++;
      $display("FAIL %s gnt_idx: got %0d want %0d", name, gnt_idx, ei);
    end
    checks++;
    if (timeout !== et) begin
      errors++;
      $display("FAIL %s timeout: got %b want %b", name, timeout, et);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic d);
    @(negedge clk);
    rst  = r;
    req  = q;
    done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;

    //          rst  req      done  gnt      idx  to
    tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b0};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b0};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0};
    tbl[8]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b0};
    tbl[11] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b0};
    tbl[12] = '{1'b1, 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[13] = '{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0};
    tbl[14] = '{1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b0};
    tbl[15] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b0};
    tbl[16] = '{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0};
    tbl[17] = '{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0};
    tbl[18] = '{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0};
    // done coincides with the hold limit: done wins, no timeout pulse
    tbl[19] = '{1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b0};
    tbl[20] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0};
    tbl[21] = '{1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0};
    tbl[22] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0};
    tbl[23] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[24] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[25] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0};

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].done);
      chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].to);
    end

    // Sole requester held with no done: continuous grant, timeout every 4th edge.
    step(1'b1, 4'b0001, 1'b0);
    chk("hold_rst", 4'b0000, 2'd0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 4'b0001, 1'b0);
      chk($sformatf("hold%0d", k), 4'b0001, 2'd0, (k > 1) && ((k - 1) % 4 == 0));
    end

    // Asynchronous reset between edges drops a live grant and resets the pointer.
    step(1'b1, 4'b0100, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    chk("async_pre", 4'b0100, 2'd2, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_mid", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    chk("async_post", 4'b0001, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requester channels, N >= 2.
REQ-002 Parameter MAX_HOLD, default 16: maximum consecutive grant cycles per owner; 0 disables the timeout.
REQ-003 clk  in  1: single clock; all state updates on its rising edge.
REQ-004 rst  in  1: reset, asynchronous and active-high.
REQ-005 req  in  N: request vector; bit i = channel i wants the resource.
REQ-006 done  in  1: current owner ends its transaction this cycle.
REQ-007 gnt  out  N: registered one-hot grant, or all-zero.
REQ-008 gnt_valid  out  1: registered; equals |gnt.
REQ-009 gnt_idx  out  $clog2(N): registered binary index of the gnt bit; 0 when gnt_valid=0.
REQ-010 timeout  out  1: registered one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-011 Internal priority pointer ptr, one-hot, N bits: its set bit is the highest-priority channel.
REQ-012 Pick function: given req and ptr at bit k, the winner is the first set req bit among indices k, k+1, ..., N-1, 0, ..., k-1; no winner if req=0.
REQ-013 FSM states: IDLE (gnt=0) and OWN (gnt one-hot, held).
REQ-014 IDLE, winner exists: next edge goes to OWN with gnt=winner and hold_cnt=0. No winner: stays in IDLE.
REQ-015 OWN, no release event: gnt unchanged; hold_cnt increments, saturating at MAX_HOLD-1.
REQ-016 Release events in OWN: done=1; req bit of the owner = 0; or MAX_HOLD>0 and hold_cnt = MAX_HOLD-1.
REQ-017 On release: ptr becomes gnt rotated left by one (wrapping N-1 to 0), so the old owner gets lowest priority.
REQ-018 Release, same edge: re-pick with the new ptr against the current req; grant with no bubble cycle and hold_cnt=0. No winner: go to IDLE.
REQ-019 An old owner that is still the sole requester is re-granted immediately, with gnt continuous and hold_cnt restarted.
REQ-020 timeout=1 on the edge after a release caused only by the MAX_HOLD limit. If done=1 in the same cycle, done wins and timeout stays 0.
REQ-021 done in IDLE is ignored.
REQ-022 ptr changes only on a release.
REQ-023 Latency from req to gnt is exactly one clock edge.
REQ-024 gnt, gnt_valid and gnt_idx are mutually consistent on every cycle.
REQ-025 gnt never has more than one bit set.
REQ-026 A gnt bit is never set for a channel whose req was 0 in the deciding cycle.
REQ-027 Fairness: with all N requesting continuously, each channel is granted once per N consecutive grants.

Reset
REQ-028 Asserting rst immediately forces: state IDLE, gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, hold_cnt=0, ptr=1 (channel 0 highest).
REQ-029 rst asserted mid-grant drops the grant asynchronously; no release side effects occur.
REQ-030 The first pick after rst deasserts happens on the first rising edge with rst=0.

Structure
REQ-031 Package rr_arbiter_pkg holds: default N, default MAX_HOLD, the state enum (IDLE, OWN), and the derived index-width constant.
REQ-032 The pick function is one combinational sub-module, rr_pick: inputs req and ptr, outputs winner one-hot.
REQ-033 rr_arbiter instantiates rr_pick once.
REQ-034 hold_cnt width is $clog2(MAX_HOLD), minimum 1.

Verification (N=4 unless stated)
REQ-035 rst=1 with req=1111 -> gnt=0000, gnt_valid=0, gnt_idx=0; after release, first edge gives gnt=0001.
REQ-036 req=1111 held, done pulsed one cycle per grant -> gnt sequence 0001, 0010, 0100, 1000, 0001, with no 0000 cycles between.
REQ-037 req=1010 from reset -> gnt=0010, gnt_idx=1; done -> 1000, gnt_idx=3; done -> 0010.
REQ-038 MAX_HOLD=4, req=0001 held, done=0 -> gnt=0001 continuously; timeout pulses every 4th cycle; hold_cnt restarts each time.
REQ-039 Owner 0100 drops req[2] while req=0011 -> next edge gnt=0001 (ptr=1000, wraps to 0); req=0000 instead -> gnt=0000, state IDLE.
REQ-040 rst pulsed asynchronously between edges while gnt=0100 -> gnt=0000 before the next edge, ptr=0001.
